awg_wave_loader: RTL and testbench

Write-side sequencer for the AWG dual-URAM waveform store. It accepts 16-bit samples from an AXI-stream slave and sequences them into the two URAM halves through the store's we/row/col/gpio_data_in write port. Each row holds 16 samples: samples 0–7 go to uram0 and samples 8–15 go to uram1. When the last sample is written, the block publishes MAX_POINTS and returns the store to playback. It sits between the PS-side DMA/FIFO and the waveform store, in the store's write-clock domain.

---
 rtl/awg_wave_loader.sv | 144 ++++++++++++++
 tb/tb_awg_wave_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/awg_wave_loader.sv
// Write-side sequencer for the AWG dual-URAM waveform store: turns an AXI-stream
// of 16-bit samples into row/col/we writes, 8 lanes per URAM half per row.
module awg_wave_loader #(
  parameter int unsigned RAM_DEPTH       = 16,
  parameter int unsigned GPIO_DATA_WIDTH = 16
) (
  input  logic                       s00_axis_aclk,
  input  logic                       s00_axis_areset,
  input  logic                       start,
  input  logic [31:0]                num_points,
  input  logic [GPIO_DATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                       s00_axis_tvalid,
  input  logic                       s00_axis_tlast,
  output logic                       s00_axis_tready,
  output logic [1:0]                 we,
  output logic [RAM_DEPTH-1:0]       row,
  output logic [2:0]                 col,
  output logic [GPIO_DATA_WIDTH-1:0] gpio_data_out,
  output logic [31:0]                MAX_POINTS,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code
);

  localparam int unsigned KW       = RAM_DEPTH + 5;
  localparam logic [32:0] MAX_ROWS = 33'd1 << RAM_DEPTH;

  localparam logic [1:0] WE_PLAY  = 2'd0;
  localparam logic [1:0] WE_URAM0 = 2'd1;
  localparam logic [1:0] WE_URAM1 = 2'd2;
  localparam logic [1:0] WE_HOLD  = 2'd3;

  localparam logic [1:0] ERR_LEN   = 2'd1;
  localparam logic [1:0] ERR_EARLY = 2'd2;
  localparam logic [1:0] ERR_NOEND = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state;
  logic [KW-1:0]   k;
  logic [KW-1:0]   last_k;
  logic [31:0]     np_m1;
  logic            abort;
  logic            len_ok;
  logic            beat;

  // Legal lengths are 1 .. 2^RAM_DEPTH rows.
  assign len_ok = (num_points != 32'd0) && ({1'b0, num_points} <= MAX_ROWS);
  assign beat   = (state == LOAD) && s00_axis_tvalid && s00_axis_tready;

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      state           <= IDLE;
      k               <= '0;
      last_k          <= '0;
      np_m1           <= '0;
      abort           <= 1'b0;
      s00_axis_tready <= 1'b0;
      we              <= WE_PLAY;
      row             <= '0;
      col             <= '0;
      gpio_data_out   <= '0;
      MAX_POINTS      <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      err_code        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              np_m1           <= num_points - 32'd1;
              // 16*num_points-1 == {num_points-1, 4'hF}
              last_k          <= KW'({num_points - 32'd1, 4'hF});
              k               <= '0;
              abort           <= 1'b0;
              err             <= 1'b0;
              err_code        <= '0;
              s00_axis_tready <= 1'b1;
              busy            <= 1'b1;
              we              <= WE_HOLD;
              state           <= LOAD;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_LEN;
            end
          end
        end

        LOAD: begin
          if (beat) begin
            we            <= k[3] ? WE_URAM1 : WE_URAM0;
            row           <= k[RAM_DEPTH+3:4];
            col           <= k[2:0];
            gpio_data_out <= s00_axis_tdata;
            k             <= k + KW'(1);
            if (k == last_k) begin
              s00_axis_tready <= 1'b0;
              state           <= FLUSH;
              if (!s00_axis_tlast) begin
                err      <= 1'b1;
                err_code <= ERR_NOEND;
              end
            end else if (s00_axis_tlast) begin
              // Early tlast: keep the beat, then abandon the load.
              s00_axis_tready <= 1'b0;
              abort           <= 1'b1;
              err             <= 1'b1;
              err_code        <= ERR_EARLY;
              state           <= FLUSH;
            end
          end else begin
            we <= WE_HOLD;
          end
        end

        FLUSH: begin
          we    <= WE_PLAY;
          busy  <= 1'b0;
          state <= IDLE;
          if (!abort) begin
            MAX_POINTS <= np_m1;
            done       <= 1'b1;
          end
        end

        default: begin
          s00_axis_tready <= 1'b0;
          busy            <= 1'b0;
          we              <= WE_PLAY;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_awg_wave_loader.sv
// Self-checking bench for awg_wave_loader: directed vector table, reset-in-load
// sequence and randomized loads scored against an arithmetic reference model.
module tb_awg_wave_loader;

  localparam int unsigned RD = 16;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   num_points;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;
  logic [1:0]    we;
  logic [RD-1:0] row;
  logic [2:0]    col;
  logic [DW-1:0] gdata;
  logic [31:0]   max_points;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;

  int checks   = 0;
  int failures = 0;
  int unsigned model_max = 0;

  awg_wave_loader #(.RAM_DEPTH(RD), .GPIO_DATA_WIDTH(DW)) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .start           (start),
    .num_points      (num_points),
    .s00_axis_tdata  (tdata),
    .s00_axis_tvalid (tvalid),
    .s00_axis_tlast  (tlast),
    .s00_axis_tready (tready),
    .we              (we),
    .row             (row),
    .col             (col),
    .gpio_data_out   (gdata),
    .MAX_POINTS      (max_points),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .err_code        (err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int unsigned np;
    int          tlast_at;   // -1: never assert tlast
    int          duty;       // valid percentage, -1: toggle every other cycle
    bit          exp_done;
    logic [1:0]  exp_code;
    int unsigned exp_max;
  } vec_t;

  // One complete load request and its full checking.
  task automatic do_load(input string tag, input int unsigned np, input int tlast_at,
                         input int duty, input bit poke, input bit exp_done,
                         input logic [1:0] exp_code, input int unsigned exp_max);
    int  last;
    int  k;
    int  cyc;
    int  budget;
    bit  v;
    bit  finished;
    bit  len_ok;
    logic [DW-1:0] d;
    len_ok = (np >= 1) && (np <= (32'd1 << RD));
    start = 1'b1;
    num_points = np;
    tick();
    start = 1'b0;
    num_points = $urandom;
    if (!len_ok) begin
      chk({tag, " bad_err"}, 64'(err), 64'd1);
      chk({tag, " bad_code"}, 64'(err_code), 64'd1);
      for (int i = 0; i < 4; i++) begin
        chk({tag, " bad_tready"}, 64'(tready), 64'd0);
        chk({tag, " bad_busy"}, 64'(busy), 64'd0);
        chk({tag, " bad_we"}, 64'(we), 64'd0);
        tick();
      end
      chk({tag, " bad_max"}, 64'(max_points), 64'(exp_max));
      return;
    end
    chk({tag, " start_tready"}, 64'(tready), 64'd1);
    chk({tag, " start_busy"}, 64'(busy), 64'd1);
    chk({tag, " start_err_clr"}, 64'(err), 64'd0);
    chk({tag, " start_code_clr"}, 64'(err_code), 64'd0);
    last = 16 * int'(np) - 1;
    budget = 16 * int'(np) * 10 + 50;
    k = 0;
    cyc = 0;
    finished = 1'b0;
    while (!finished && cyc < budget) begin
      if (duty < 0) v = (cyc % 2) == 1;
      else v = ($urandom_range(99) < 32'(duty));
      tvalid = v;
      d = DW'($urandom);
      tdata = d;
      tlast = v ? (k == tlast_at) : 1'($urandom);
      if (poke) begin
        start = ($urandom_range(9) == 0);
        num_points = 32'd0;
      end
      chk({tag, " load_tready"}, 64'(tready), 64'd1);
      tick();
      if (v) begin
        chk({tag, " wr_we"}, 64'(we), ((k / 8) % 2 == 1) ? 64'd2 : 64'd1);
        chk({tag, " wr_row"}, 64'(row), 64'(k / 16));
        chk({tag, " wr_col"}, 64'(col), 64'(k % 8));
        chk({tag, " wr_data"}, 64'(gdata), 64'(d));
        if (k == last || k == tlast_at) finished = 1'b1;
        k++;
      end else begin
        chk({tag, " idle_we_hold"}, 64'(we), 64'd3);
      end
      cyc++;
    end
    start = 1'b0;
    tvalid = 1'b0;
    tlast = 1'b0;
    chk({tag, " timeout"}, 64'(finished), 64'd1);
    chk({tag, " flush_tready"}, 64'(tready), 64'd0);
    chk({tag, " flush_busy"}, 64'(busy), 64'd1);
    chk({tag, " flush_done"}, 64'(done), 64'd0);
    tick();
    chk({tag, " end_we"}, 64'(we), 64'd0);
    chk({tag, " end_done"}, 64'(done), 64'(exp_done));
    chk({tag, " end_busy"}, 64'(busy), 64'd0);
    chk({tag, " end_tready"}, 64'(tready), 64'd0);
    chk({tag, " end_max"}, 64'(max_points), 64'(exp_max));
    chk({tag, " end_err"}, 64'(err), (exp_code != 2'd0) ? 64'd1 : 64'd0);
    chk({tag, " end_code"}, 64'(err_code), 64'(exp_code));
    tick();
    chk({tag, " done_pulse"}, 64'(done), 64'd0);
    chk({tag, " hold_code"}, 64'(err_code), 64'(exp_code));
    chk({tag, " hold_tready"}, 64'(tready), 64'd0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{np: 2,     tlast_at: 31, duty: 100, exp_done: 1'b1, exp_code: 2'd0, exp_max: 1};
    vecs[1] = '{np: 2,     tlast_at: 31, duty: -1,  exp_done: 1'b1, exp_code: 2'd0, exp_max: 1};
    vecs[2] = '{np: 0,     tlast_at: -1, duty: 100, exp_done: 1'b0, exp_code: 2'd1, exp_max: 1};
    vecs[3] = '{np: 65537, tlast_at: -1, duty: 100, exp_done: 1'b0, exp_code: 2'd1, exp_max: 1};
    vecs[4] = '{np: 2,     tlast_at: 20, duty: 100, exp_done: 1'b0, exp_code: 2'd2, exp_max: 1};
    vecs[5] = '{np: 1,     tlast_at: -1, duty: 100, exp_done: 1'b1, exp_code: 2'd3, exp_max: 0};
    vecs[6] = '{np: 3,     tlast_at: 47, duty: 60,  exp_done: 1'b1, exp_code: 2'd0, exp_max: 2};

    rst = 1'b1;
    start = 1'b0;
    num_points = '0;
    tdata = '0;
    tvalid = 1'b0;
    tlast = 1'b0;
    tick();
    tick();
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_row", 64'(row), 64'd0);
    chk("rst_col", 64'(col), 64'd0);
    chk("rst_data", 64'(gdata), 64'd0);
    chk("rst_max", 64'(max_points), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_code", 64'(err_code), 64'd0);
    chk("rst_tready", 64'(tready), 64'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      do_load($sformatf("vec%0d", i), vecs[i].np, vecs[i].tlast_at, vecs[i].duty, 1'b0,
              vecs[i].exp_done, vecs[i].exp_code, vecs[i].exp_max);
      tick();
    end
    model_max = 2;

    // Reset while beat 7 of a single-row load is on the bus.
    start = 1'b1;
    num_points = 32'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tvalid = 1'b1;
      tdata = DW'($urandom);
      tick();
    end
    tdata = DW'($urandom);
    rst = 1'b1;
    #1;
    chk("midrst_we", 64'(we), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_tready", 64'(tready), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_max", 64'(max_points), 64'd0);
    model_max = 0;
    tvalid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    do_load("after_rst", 1, 15, 100, 1'b0, 1'b1, 2'd0, 0);
    tick();

    for (int it = 0; it < 14; it++) begin
      int unsigned np;
      int          last;
      int          sc;
      int          tl;
      bit          good;
      bit          edone;
      logic [1:0]  ecode;
      if ($urandom_range(6) == 0)
        np = ($urandom_range(1) == 0) ? 32'd0 : (32'd1 << RD) + $urandom_range(1, 1000);
      else
        np = $urandom_range(1, 4);
      good = (np >= 1) && (np <= (32'd1 << RD));
      last = 16 * int'(np) - 1;
      sc = int'($urandom_range(2));
      if (sc == 0) tl = last;
      else if (sc == 1) tl = int'($urandom_range(32'(last - 1)));
      else tl = -1;
      if (!good) begin
        ecode = 2'd1;
        edone = 1'b0;
      end else begin
        ecode = (sc == 1) ? 2'd2 : ((sc == 2) ? 2'd3 : 2'd0);
        edone = (sc != 1);
        if (edone) model_max = np - 1;
      end
      do_load($sformatf("rnd%0d", it), np, tl, int'($urandom_range(30, 100)),
              1'($urandom_range(1)), edone, ecode, model_max);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
